// File: rtl/multiword_adder_sequencer.sv
// ---------------------------------------------------------------------------
// multiword_adder_sequencer
//
// Multi-precision add/subtract controller. One WORD_WIDTH-bit carry-select
// adder is reused across WORDS operand words, least-significant word first.
// The carry between words is held in a register, so an N-bit operation
// (N = WORD_WIDTH*WORDS) takes WORDS cycles but the critical path is a
// single narrow adder.
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   : operand handshake (op_sub, cin, a, b)
//   op_sub              : 0 = a+b+cin, 1 = a-b (cin ignored)
//   out_valid/out_ready : result handshake (result, cout, overflow)
//   cout                : final carry; for subtract 1 means no borrow
//   overflow            : two's-complement signed overflow of the N-bit op
//   busy                : operation in flight or result waiting
// ---------------------------------------------------------------------------

// Carry-select adder: each block precomputes its sum for carry-in 0 and 1,
// and the incoming block carry only drives a mux.
module carry_select_adder #(
    parameter int WIDTH      = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NB = (WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;

    logic [NB-1:0] blk_c0;   // block carry-out assuming carry-in 0
    logic [NB-1:0] blk_c1;   // block carry-out assuming carry-in 1
    logic [NB-1:0] blk_cin;  // resolved carry into each block

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_blk
            localparam int LO = gi * BLOCK_SIZE;
            localparam int HI = (LO + BLOCK_SIZE > WIDTH) ? WIDTH : LO + BLOCK_SIZE;
            localparam int BW = HI - LO;
            logic [BW:0] s0;
            logic [BW:0] s1;
            assign s0 = {1'b0, a[HI-1:LO]} + {1'b0, b[HI-1:LO]};
            assign s1 = {1'b0, a[HI-1:LO]} + {1'b0, b[HI-1:LO]} + (BW+1)'(1);
            assign blk_c0[gi] = s0[BW];
            assign blk_c1[gi] = s1[BW];
            assign sum[HI-1:LO] = blk_cin[gi] ? s1[BW-1:0] : s0[BW-1:0];
        end
    endgenerate

    // Resolve the select chain with a local variable so no vector feeds
    // back on itself.
    always_comb begin
        logic c;
        blk_cin = '0;
        c       = cin;
        for (int i = 0; i < NB; i++) begin
            blk_cin[i] = c;
            c          = c ? blk_c1[i] : blk_c0[i];
        end
        cout = c;
    end
endmodule

module multiword_adder_sequencer #(
    parameter int WORD_WIDTH = 8,
    parameter int WORDS      = 4,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        op_sub,
    input  logic                        cin,
    input  logic [WORD_WIDTH*WORDS-1:0] a,
    input  logic [WORD_WIDTH*WORDS-1:0] b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_WIDTH*WORDS-1:0] result,
    output logic                        cout,
    output logic                        overflow,
    output logic                        busy
);
    localparam int N     = WORD_WIDTH * WORDS;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_sh_q, a_sh_d;
    logic [N-1:0]    b_sh_q, b_sh_d;     // holds ~B for subtract
    logic [N-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [WORD_WIDTH-1:0] add_sum;
    logic                  add_cout;

    carry_select_adder #(
        .WIDTH      (WORD_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_adder (
        .a    (a_sh_q[WORD_WIDTH-1:0]),
        .b    (b_sh_q[WORD_WIDTH-1:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = op_sub ? ~b : b;
                    // Subtract is A + ~B + 1, so the +1 enters as carry-in.
                    carry_d = op_sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Sums enter at the top; after WORDS shifts word 0 sits lowest.
                res_d   = {add_sum, res_q[N-1:WORD_WIDTH]};
                a_sh_d  = a_sh_q >> WORD_WIDTH;
                b_sh_d  = b_sh_q >> WORD_WIDTH;
                carry_d = add_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_WORD) begin
                    state_d = S_DONE;
                    cout_d  = add_cout;
                    // Same-sign operands producing a different-sign sum.
                    ovf_d   = ~(a_sh_q[WORD_WIDTH-1] ^ b_sh_q[WORD_WIDTH-1])
                              & (a_sh_q[WORD_WIDTH-1] ^ add_sum[WORD_WIDTH-1]);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // All handshake outputs decode from state only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for multiword_adder_sequencer (WORD_WIDTH=8, WORDS=4, N=32).
// Expected results are produced by a 64-bit reference model when a request
// is driven and queued; a negedge monitor queues every result handshake and
// the scenario tasks pop and compare the two.
// ---------------------------------------------------------------------------
module tb_multiword_adder_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        cout;
    logic        overflow;
    logic        busy;

    multiword_adder_sequencer #(
        .WORD_WIDTH (8),
        .WORDS      (4),
        .BLOCK_SIZE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        o;
        int          cyc;
    } obs_t;

    exp_t sb[$];
    obs_t obs[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each result handshake (valid & ready seen before the edge).
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            obs.push_back('{r: result, c: cout, o: overflow, cyc: cyc});
        end
    end

    function automatic exp_t model(input logic sub, input logic ci,
                                   input logic [31:0] aa, input logic [31:0] bb);
        exp_t        e;
        logic [32:0] t;
        longint      sa, sbv, sr;
        sa  = longint'($signed(aa));
        sbv = longint'($signed(bb));
        if (sub) begin
            t   = {1'b0, aa} - {1'b0, bb};
            e.c = (aa >= bb);
            sr  = sa - sbv;
        end else begin
            t   = {1'b0, aa} + {1'b0, bb} + {32'd0, ci};
            e.c = t[32];
            sr  = sa + sbv + longint'(ci);
        end
        e.r = t[31:0];
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and hold it until accepted; acc is the accept cycle.
    task automatic issue(input logic sub, input logic ci, input logic [31:0] aa,
                         input logic [31:0] bb, input bit push, output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        if (push) sb.push_back(model(sub, ci, aa, bb));
        op_sub   = sub;
        cin      = ci;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) begin
                tick();
                acc  = cyc;
                done = 1'b1;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: in_ready never high, required within 50 cycles");
        end
    endtask

    // Wait (bounded) for a captured result, then pop it with its expectation.
    task automatic pop_pair(output exp_t e, output obs_t o, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && obs.size() == 0; i++) tick();
        if (obs.size() != 0 && sb.size() != 0) begin
            e  = sb.pop_front();
            o  = obs.pop_front();
            ok = 1'b1;
        end else begin
            errors++;
            checks++;
            $display("FAIL result_timeout: obs=%0d exp=%0d queued, required one of each",
                     obs.size(), sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 6;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
    endtask

    task automatic test_add_carry();
        int acc; exp_t e; obs_t o; bit ok;
        out_ready = 1'b1;
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, acc);
        pop_pair(e, o, ok);
        if (ok) begin
            checks += 2;
            if ({o.r, o.c, o.o} !== {e.r, e.c, e.o}) begin
                errors++;
                $display("FAIL add_carry: got %h c=%b v=%b want %h c=%b v=%b", o.r, o.c, o.o, e.r, e.c, e.o);
            end
            if (o.cyc - acc !== 4) begin
                errors++;
                $display("FAIL add_latency: got %0d want 4", o.cyc - acc);
            end
            $display("add FFFFFFFF+1: result=%h cout=%b ovf=%b latency=%0d", o.r, o.c, o.o, o.cyc - acc);
        end
    endtask

    task automatic test_sub_borrow();
        int acc; exp_t e; obs_t o; bit ok;
        issue(1'b1, 1'b1, 32'd5, 32'd7, 1'b1, acc);
        pop_pair(e, o, ok);
        if (ok) begin
            checks++;
            if ({o.r, o.c, o.o} !== {e.r, e.c, e.o}) begin
                errors++;
                $display("FAIL sub_borrow: got %h c=%b v=%b want %h c=%b v=%b", o.r, o.c, o.o, e.r, e.c, e.o);
            end
            $display("sub 5-7: result=%h cout=%b ovf=%b", o.r, o.c, o.o);
        end
    endtask

    task automatic test_overflow();
        int acc; exp_t e; obs_t o; bit ok;
        issue(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b1, acc);
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h1, 1'b1, acc);
        for (int k = 0; k < 2; k++) begin
            pop_pair(e, o, ok);
            if (ok) begin
                checks++;
                if ({o.r, o.c, o.o} !== {e.r, e.c, e.o}) begin
                    errors++;
                    $display("FAIL overflow_%0d: got %h c=%b v=%b want %h c=%b v=%b", k, o.r, o.c, o.o, e.r, e.c, e.o);
                end
                $display("overflow case %0d: result=%h cout=%b ovf=%b", k, o.r, o.c, o.o);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1, acc2; exp_t e; obs_t o; bit ok;
        out_ready = 1'b1;
        issue(1'b0, 1'b1, 32'h0000_00FF, 32'h0, 1'b1, acc0);
        issue(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, acc1);
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0001, 1'b1, acc2);
        checks += 2;
        if (acc1 - acc0 !== 6) begin errors++; $display("FAIL b2b_spacing_1: got %0d want 6", acc1 - acc0); end
        if (acc2 - acc1 !== 6) begin errors++; $display("FAIL b2b_spacing_2: got %0d want 6", acc2 - acc1); end
        for (int k = 0; k < 3; k++) begin
            pop_pair(e, o, ok);
            if (ok) begin
                checks++;
                if ({o.r, o.c, o.o} !== {e.r, e.c, e.o}) begin
                    errors++;
                    $display("FAIL b2b_%0d: got %h c=%b v=%b want %h c=%b v=%b", k, o.r, o.c, o.o, e.r, e.c, e.o);
                end
                $display("b2b %0d: result=%h cout=%b ovf=%b", k, o.r, o.c, o.o);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc; exp_t e; obs_t o; bit ok;
        logic [31:0] cap_r; logic cap_c, cap_o;
        out_ready = 1'b0;
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, acc);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        cap_r = result;
        cap_c = cout;
        cap_o = overflow;
        // A competing request while DONE must be ignored.
        op_sub   = 1'b0;
        a        = 32'h5555_5555;
        b        = 32'h1111_1111;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 3;
            if ({result, cout, overflow} !== {cap_r, cap_c, cap_o}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got %h/%b/%b want %h/%b/%b", k, result, cout, overflow, cap_r, cap_c, cap_o);
            end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_%0d: got %b want 1", k, out_valid); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b want 0", busy); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_req: busy=%b want 0", busy); end
        pop_pair(e, o, ok);
        if (ok) begin
            checks++;
            if ({o.r, o.c, o.o} !== {e.r, e.c, e.o}) begin
                errors++;
                $display("FAIL bp_result: got %h c=%b v=%b want %h c=%b v=%b", o.r, o.c, o.o, e.r, e.c, e.o);
            end
            $display("backpressure: result=%h cout=%b ovf=%b", o.r, o.c, o.o);
        end
    endtask

    task automatic test_reset_mid_run();
        int acc; exp_t e; obs_t o; bit ok;
        out_ready = 1'b1;
        issue(1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, acc);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_run_in_ready: got %b want 1", in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b want 0", busy); end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (obs.size() !== 0) begin errors++; $display("FAIL rst_run_discard: got %0d results want 0", obs.size()); end
        issue(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, acc);
        pop_pair(e, o, ok);
        if (ok) begin
            checks += 2;
            if ({o.r, o.c, o.o} !== {e.r, e.c, e.o}) begin
                errors++;
                $display("FAIL rst_run_next: got %h c=%b v=%b want %h c=%b v=%b", o.r, o.c, o.o, e.r, e.c, e.o);
            end
            if (o.r !== 32'h2345_6789) begin errors++; $display("FAIL rst_run_literal: got %h want 23456789", o.r); end
            $display("after mid-run reset: result=%h cout=%b ovf=%b", o.r, o.c, o.o);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int acc; exp_t e; obs_t o; bit ok;
        logic sub, ci; logic [31:0] ra, rb;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sub = 1'($urandom_range(0, 1));
            ci  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            issue(sub, ci, ra, rb, 1'b1, acc);
            pop_pair(e, o, ok);
            if (ok) begin
                checks++;
                if ({o.r, o.c, o.o} !== {e.r, e.c, e.o}) begin
                    errors++;
                    $display("FAIL random_%0d: got %h c=%b v=%b want %h c=%b v=%b", k, o.r, o.c, o.o, e.r, e.c, e.o);
                end
                $display("random %0d: sub=%b %h,%h -> %h c=%b v=%b", k, sub, ra, rb, o.r, o.c, o.o);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
